// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package ram_pkg;

    localparam int unsigned RF_MODE     = 0;
    localparam int unsigned WF_MODE     = 1;
    localparam int unsigned MERGE_MAX_W = 512;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Per-bit select of new vs old word; bit i belongs to lane i/lane_w.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] be,
        input int unsigned            lane_w
    );
        logic [MERGE_MAX_W-1:0] r;
        for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
            r[i] = be[i / lane_w] ? new_word[i] : old_word[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: walks every address once after reset or on request.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_we_c,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              busy_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_CLEAR;
            o_clr_addr <= '0;
            o_busy     <= 1'b1;
        end else begin
            state      <= state_nxt;
            o_clr_addr <= addr_nxt;
            o_busy     <= busy_nxt;
        end
    end

    // Requests during CLEAR are ignored; the walk never restarts mid-way.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = o_clr_addr;
        o_clr_we_c = 1'b0;
        case (state)
            ST_CLEAR: begin
                o_clr_we_c = 1'b1;
                addr_nxt   = o_clr_addr + ADDR_W'(1);
                if (o_clr_addr == LAST_ADDR) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (i_clr) begin
                    state_nxt = ST_CLEAR;
                    addr_nxt  = '0;
                end
            end
        endcase
        busy_nxt = (state_nxt == ST_CLEAR);
    end

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM with lane enables, read-during-write mode,
// 1/2-cycle read latency and a built-in clear sequencer.
module param_sp_ram
    import ram_pkg::*;
#(
    parameter int unsigned     DATA_W     = 8,
    parameter int unsigned     ADDR_W     = 6,
    parameter int unsigned     LANE_W     = 8,
    parameter int unsigned     RD_LATENCY = 1,
    parameter int unsigned     WRITE_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ce,
    input  logic                     i_we,
    input  logic [DATA_W/LANE_W-1:0] i_be,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_clr,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic                     o_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we_c;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc_c;
    logic [DATA_W-1:0] old_word_c;
    logic [DATA_W-1:0] merged_c;
    logic [DATA_W-1:0] resp_c;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    ram_clear_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .o_busy     (busy),
        .o_clr_we_c (clr_we_c),
        .o_clr_addr (clr_addr)
    );

    assign o_busy = busy;

    // A clear request in the same cycle as an access drops the access.
    always_comb begin
        acc_c      = i_ce & ~busy & ~i_clr;
        old_word_c = mem[i_addr];
        merged_c   = DATA_W'(lane_merge(MERGE_MAX_W'(old_word_c), MERGE_MAX_W'(i_data),
                                        MERGE_MAX_W'(i_be), LANE_W));
        resp_c     = (WRITE_MODE == WF_MODE && i_we) ? merged_c : old_word_c;
    end

    always_ff @(posedge i_clk) begin
        if (clr_we_c) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (acc_c && i_we) begin
            mem[i_addr] <= merged_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= acc_c;
            if (acc_c) begin
                s1_data <= resp_c;
            end
        end
    end

    // Optional second stage; data only moves when a valid word moves.
    if (RD_LATENCY >= 2) begin : g_lat2
        logic [DATA_W-1:0] s2_data;
        logic              s2_valid;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign o_data  = s2_data;
        assign o_valid = s2_valid;
    end else begin : g_lat1
        assign o_data  = s1_data;
        assign o_valid = s1_valid;
    end

endmodule

// File: tb/tb_param_sp_ram.sv
// Scoreboard bench for param_sp_ram across four parameter sets.
module tb_param_sp_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst, ce, clr;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;

    logic [7:0]  d0, d2, d3;
    logic [15:0] d1;
    logic        v0, v1, v2, v3;
    logic        b0, b1, b2, b3;

    int checks = 0;
    int errors = 0;
    int c0, c1, c2, c3;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] q3[$];

    param_sp_ram u0 (
        .i_clk(clk), .i_rst(rst[0]), .i_ce(ce[0]), .i_we(we), .i_be(be[0:0]),
        .i_addr(addr), .i_data(data[7:0]), .i_clr(clr[0]),
        .o_data(d0), .o_valid(v0), .o_busy(b0)
    );

    param_sp_ram #(.DATA_W(16)) u1 (
        .i_clk(clk), .i_rst(rst[1]), .i_ce(ce[1]), .i_we(we), .i_be(be),
        .i_addr(addr), .i_data(data), .i_clr(clr[1]),
        .o_data(d1), .o_valid(v1), .o_busy(b1)
    );

    param_sp_ram #(.WRITE_MODE(1)) u2 (
        .i_clk(clk), .i_rst(rst[2]), .i_ce(ce[2]), .i_we(we), .i_be(be[0:0]),
        .i_addr(addr), .i_data(data[7:0]), .i_clr(clr[2]),
        .o_data(d2), .o_valid(v2), .o_busy(b2)
    );

    param_sp_ram #(.RD_LATENCY(2), .INIT_VAL(8'h5A)) u3 (
        .i_clk(clk), .i_rst(rst[3]), .i_ce(ce[3]), .i_we(we), .i_be(be[0:0]),
        .i_addr(addr), .i_data(data[7:0]), .i_clr(clr[3]),
        .o_data(d3), .o_valid(v3), .o_busy(b3)
    );

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic mon(input int n, input logic v, input logic [15:0] d);
        logic [15:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        if (v === 1'b1) begin
            case (n)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
                chk($sformatf("resp_dut%0d", n), d, e);
            end else begin
                checks++;
                errors++;
                $display("FAIL stray_valid_dut%0d: got valid with data %h expected no response", n, d);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, v0, {8'h00, d0});
        mon(1, v1, d1);
        mon(2, v2, {8'h00, d2});
        mon(3, v3, {8'h00, d3});
    end

    // Drive one access for a cycle; optionally queue its expected response.
    task automatic acc(input int n, input logic w, input logic [5:0] a, input logic [15:0] dv,
                       input logic [1:0] bv, input logic [15:0] e, input bit push);
        we      = w;
        addr    = a;
        data    = dv;
        be      = bv;
        ce[n]   = 1'b1;
        if (push) begin
            case (n)
                0: q0.push_back(e);
                1: q1.push_back(e);
                2: q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
        @(negedge clk);
        ce[n] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 4'hF; ce = '0; clr = '0; we = 1'b0; addr = '0; data = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid0", {15'h0, v0}, 16'h0);
        chk("rst_data3", {8'h0, d3}, 16'h0);
        chk("rst_busy0", {15'h0, b0}, 16'h1);
        chk("rst_busy3", {15'h0, b3}, 16'h1);

        // Power-up clear length for every instance
        rst = 4'h0;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int k = 0; k < 100; k++) begin
            if (b0) c0++;
            if (b1) c1++;
            if (b2) c2++;
            if (b3) c3++;
            @(negedge clk);
        end
        chk("pwrup_busy_dut0", 16'(c0), 16'd64);
        chk("pwrup_busy_dut1", 16'(c1), 16'd64);
        chk("pwrup_busy_dut2", 16'(c2), 16'd64);
        chk("pwrup_busy_dut3", 16'(c3), 16'd64);

        acc(0, 1'b0, 6'd5, 16'h0, 2'b00, 16'h00, 1'b1);
        chk("lat1_valid", {15'h0, v0}, 16'h1);
        @(negedge clk);
        chk("idle_valid", {15'h0, v0}, 16'h0);

        for (int i = 0; i < 64; i++) acc(0, 1'b1, 6'(i), 16'(i + 1), 2'b01, 16'h00, 1'b1);
        for (int i = 0; i < 64; i++) begin
            acc(0, 1'b0, 6'(i), 16'h0, 2'b00, 16'(i + 1), 1'b1);
            chk("rd_stream_valid", {15'h0, v0}, 16'h1);
        end
        @(negedge clk);
        chk("hold_valid", {15'h0, v0}, 16'h0);
        chk("hold_data", {8'h0, d0}, 16'h0040);

        // Read-during-write, READ_FIRST
        acc(0, 1'b1, 6'd7, 16'h11, 2'b01, 16'h08, 1'b1);
        acc(0, 1'b1, 6'd7, 16'h22, 2'b01, 16'h11, 1'b1);
        acc(0, 1'b0, 6'd7, 16'h00, 2'b00, 16'h22, 1'b1);
        acc(0, 1'b1, 6'd9, 16'hFF, 2'b00, 16'h0A, 1'b1);
        acc(0, 1'b0, 6'd9, 16'h00, 2'b00, 16'h0A, 1'b1);
        acc(0, 1'b0, 6'd63, 16'h00, 2'b00, 16'h40, 1'b1);

        // Lane enables on a 16-bit word
        acc(1, 1'b1, 6'd3, 16'hABCD, 2'b11, 16'h0000, 1'b1);
        acc(1, 1'b1, 6'd3, 16'h1234, 2'b01, 16'hABCD, 1'b1);
        acc(1, 1'b0, 6'd3, 16'h0000, 2'b00, 16'hAB34, 1'b1);
        acc(1, 1'b1, 6'd3, 16'h5600, 2'b10, 16'hAB34, 1'b1);
        acc(1, 1'b0, 6'd3, 16'h0000, 2'b00, 16'h5634, 1'b1);

        // Read-during-write, WRITE_FIRST
        acc(2, 1'b1, 6'd7, 16'h11, 2'b01, 16'h11, 1'b1);
        acc(2, 1'b1, 6'd7, 16'h22, 2'b01, 16'h22, 1'b1);
        acc(2, 1'b0, 6'd7, 16'h00, 2'b00, 16'h22, 1'b1);
        acc(2, 1'b1, 6'd7, 16'h99, 2'b00, 16'h22, 1'b1);
        acc(2, 1'b0, 6'd7, 16'h00, 2'b00, 16'h22, 1'b1);

        // Two-cycle latency, INIT_VAL 0x5A
        acc(3, 1'b0, 6'd40, 16'h0, 2'b00, 16'h5A, 1'b1);
        chk("lat2_early_valid", {15'h0, v3}, 16'h0);
        @(negedge clk);
        chk("lat2_valid", {15'h0, v3}, 16'h1);
        for (int i = 0; i < 64; i++) acc(3, 1'b1, 6'(i), 16'(i + 1), 2'b01, 16'h5A, 1'b1);
        acc(3, 1'b0, 6'd40, 16'h0, 2'b00, 16'h29, 1'b1);
        repeat (4) @(negedge clk);

        // Clear request with a colliding read, then reads while busy
        clr[3] = 1'b1; ce[3] = 1'b1; we = 1'b0; addr = 6'd40;
        @(negedge clk);
        clr[3] = 1'b0; ce[3] = 1'b0;
        c3 = 0;
        for (int k = 0; k < 100; k++) begin
            if (b3) c3++;
            if (k < 60) begin
                ce[3] = 1'b1;
                addr  = 6'(k);
            end else begin
                ce[3] = 1'b0;
            end
            @(negedge clk);
        end
        ce[3] = 1'b0;
        chk("clr_busy_cycles", 16'(c3), 16'd64);
        acc(3, 1'b0, 6'd40, 16'h0, 2'b00, 16'h5A, 1'b1);
        chk("post_clr_early", {15'h0, v3}, 16'h0);
        @(negedge clk);
        chk("post_clr_valid", {15'h0, v3}, 16'h1);

        // Reset with reads in flight
        acc(3, 1'b0, 6'd40, 16'h0, 2'b00, 16'h5A, 1'b1);
        acc(3, 1'b0, 6'd41, 16'h0, 2'b00, 16'h5A, 1'b1);
        #2 rst[3] = 1'b1;
        #1;
        chk("flight_rst_valid", {15'h0, v3}, 16'h0);
        chk("flight_rst_data", {8'h0, d3}, 16'h0);
        chk("flight_rst_busy", {15'h0, b3}, 16'h1);
        q3.delete();
        @(negedge clk);
        rst[3] = 1'b0;
        c3 = 0;
        for (int k = 0; k < 100; k++) begin
            if (b3) c3++;
            @(negedge clk);
        end
        chk("flight_rst_busy_cycles", 16'(c3), 16'd64);

        // Reset in the middle of a clear walk
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst[0] = 1'b1;
        #1;
        chk("midclr_rst_valid", {15'h0, v0}, 16'h0);
        chk("midclr_rst_data", {8'h0, d0}, 16'h0);
        chk("midclr_rst_busy", {15'h0, b0}, 16'h1);
        q0.delete();
        @(negedge clk);
        rst[0] = 1'b0;
        c0 = 0;
        for (int k = 0; k < 100; k++) begin
            if (b0) c0++;
            @(negedge clk);
        end
        chk("midclr_busy_cycles", 16'(c0), 16'd64);
        acc(0, 1'b0, 6'd7, 16'h0, 2'b00, 16'h00, 1'b1);
        acc(0, 1'b0, 6'd63, 16'h0, 2'b00, 16'h00, 1'b1);

        repeat (5) @(negedge clk);
        chk("pending_dut0", 16'(q0.size()), 16'd0);
        chk("pending_dut1", 16'(q1.size()), 16'd0);
        chk("pending_dut2", 16'(q2.size()), 16'd0);
        chk("pending_dut3", 16'(q3.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_sp_ram.md
Name: param_sp_ram

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 64x8 single-port RAM.
- Adds generic width and depth, per-lane byte-enable writes, selectable read-during-write mode, and configurable read latency with an output valid.
- Adds a built-in clear sequencer that fills memory with INIT_VAL after reset or on request.
- Used as the general scratch/buffer memory in datapath blocks.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of LANE_W.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- LANE_W, 8, bits per byte-enable lane; NUM_LANES = DATA_W/LANE_W.
- RD_LATENCY, 1, cycles from accepted access to o_valid; legal values 1 or 2.
- WRITE_MODE, 0, read-during-write result: 0 = READ_FIRST (old word), 1 = WRITE_FIRST (merged new word).
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ce  in  1  access enable.
- i_we  in  1  1 = write, 0 = read; qualified by i_ce.
- i_be  in  NUM_LANES  lane write enables; ignored for reads.
- i_addr  in  ADDR_W  word address.
- i_data  in  DATA_W  write data.
- i_clr  in  1  one-cycle pulse that starts a clear sequence.
- o_data  out  DATA_W  read data.
- o_valid  out  1  o_data is valid this cycle.
- o_busy  out  1  clear sequence in progress; accesses are ignored while high.

Behaviour:
- Reset (asynchronous):
  - o_data=0, o_valid=0, whole latency pipeline cleared.
  - FSM enters CLEAR with clr_addr=0; o_busy=1 while i_rst is high and throughout CLEAR.
- FSM states: CLEAR and READY.
- CLEAR:
  - Each cycle: mem[clr_addr] <= INIT_VAL, then clr_addr+1.
  - After writing address DEPTH-1, go to READY; CLEAR lasts exactly DEPTH cycles.
  - i_clr during CLEAR is ignored; the sequence does not restart.
- READY:
  - o_busy=0.
  - i_clr=1 moves to CLEAR next cycle with clr_addr=0.
  - If i_clr and i_ce are both high in the same cycle, the access is dropped.
- Access acceptance: acc = i_ce & ~o_busy & ~i_clr.
- Write (acc & i_we): at the edge, for each lane k with i_be[k]=1, mem[i_addr] lane k <= i_data lane k. Lanes with i_be[k]=0 are unchanged. i_be=0 is a legal no-op write.
- Read data: every accepted access, read or write, returns a word.
  - Reads return mem[i_addr].
  - Writes return the old word when WRITE_MODE=0.
  - Writes return the lane-merged new word when WRITE_MODE=1.
- Latency:
  - RD_LATENCY=1: o_data/o_valid update at the edge that samples the access.
  - RD_LATENCY=2: one extra register stage; the valid bit travels with the data.
  - Back-to-back accesses give a full-throughput o_valid stream.
- When no access is accepted, o_valid=0 at the matching output cycle and o_data holds its last value.
- Accesses in flight when CLEAR starts still complete; data returned is pre-clear contents.
- Address wrap: the full 2**ADDR_W range is valid, so there are no out-of-range cases.
- Reset during CLEAR or with accesses in flight: outputs go to reset values immediately and the pipeline is flushed. After release, CLEAR restarts from address 0 for the full DEPTH cycles.
- Memory contents are undefined between reset assertion and completion of CLEAR.

Decomposition:
- Package ram_pkg:
  - WRITE_MODE constants RF_MODE=0, WF_MODE=1.
  - State encoding constants ST_CLEAR, ST_READY.
  - Function for the lane-merge of old/new word under i_be.
- Sub-module ram_clear_fsm: state register, clr_addr counter, o_busy, and the clear write-enable/address/data mux select.
- The storage array, merge logic and latency pipeline stay in param_sp_ram.

Test Plan:
- Power-up clear (defaults, INIT_VAL=0): release i_rst -> o_busy=1 for exactly 64 cycles then 0. Then read addr 5 -> next cycle o_valid=1, o_data=0x00.
- Fill and readback (defaults): write addr i, data i+1, i_be=1, for i=0..63, then read 0..63.
  - Read responses: o_data=i+1 one cycle after each read, o_valid continuous.
  - Write responses: old contents 0x00 (READ_FIRST).
- Byte enable (DATA_W=16): write 0xABCD to addr 3 with be=11, then write 0x1234 with be=01 -> read addr 3 returns 0xAB34.
- Read-during-write: with mem[7]=0x11, write 0x22 to addr 7.
  - WRITE_MODE=0 -> o_data=0x11.
  - WRITE_MODE=1 -> o_data=0x22.
  - Subsequent read of addr 7 -> 0x22 in both modes.
- Clear on request (INIT_VAL=0x5A, RD_LATENCY=2):
  - After filling memory, pulse i_clr -> o_busy high for 64 cycles.
  - Reads issued while busy -> o_valid stays 0.
  - After busy falls, read addr 40 -> o_valid=1 and o_data=0x5A two cycles later.
- Reset mid-operation: assert i_rst while clr_addr=20 with two reads in flight.
  - Immediately: o_valid=0, o_data=0.
  - After release: o_busy high for the full 64 cycles.
  - Then: no stale o_valid pulses.
